// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types, byte-mask constants and helpers for the RV32I
//             data-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    // Only naturally aligned byte, halfword and word accesses are legal.
    function automatic logic mask_legal(input logic [3:0] m);
        case (m)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3,
            MASK_H0, MASK_H1, MASK_W: mask_legal = 1'b1;
            default:                  mask_legal = 1'b0;
        endcase
    endfunction

    // Expand a byte-lane mask to a 32-bit bit mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if
//  Purpose  : Core <-> data-memory load/store handshake bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_valid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    // Core side issues requests and consumes responses.
    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
        input  dmem_valid, dmem_rdata, dmem_err
    );

    // Memory side consumes requests and produces responses.
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
        output dmem_valid, dmem_rdata, dmem_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder_sram.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_sram
//  Purpose  : Synchronous single-port 32-bit word array with byte enables.
//             Read data is registered and only changes on an enabled read.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  wire logic                           clk,
    input  wire logic                           en_i,
    input  wire logic                           we_i,
    input  wire logic [3:0]                     be_i,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  wire logic [31:0]                    wdata_i,
    output logic      [31:0]                    rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];

    // Byte-masked write or registered read of one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_o <= mem_q[idx_i];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Far end of the RV32I load/store handshake. Serves one request
//             at a time with a fixed wait-state count, flags illegal masks
//             and out-of-range addresses.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dmem_if.slave     bus
);
    localparam int         c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYCLES - 1);

    dmem_state_e     state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [c_AW-1:0] idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      mask_q;
    logic            bad_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            w_bad;
    logic            w_exit;
    logic            w_sram_en;
    logic [c_AW-1:0] w_sram_idx;
    logic [31:0]     w_sram_rdata;
    logic [1:0]      w_unused_addr;

    assign w_unused_addr = bus.dmem_addr[1:0];

    // Illegal byte mask or word index beyond the array.
    assign w_bad = !mask_legal(bus.dmem_mask) ||
                   (32'(bus.dmem_addr[31:2]) >= 32'(DEPTH_WORDS));

    assign w_exit = (state_q == WAIT) && (cnt_q == 4'd0);

    // Loads read the array at acceptance (accesses are serialised, so the
    // word cannot change before the response); stores commit on WAIT exit
    // so a reset during WAIT drops them.
    assign w_sram_en  = (state_q == IDLE) ? (bus.dmem_req && !bus.dmem_we)
                                          : (w_exit && we_q && !bad_q);
    assign w_sram_idx = (state_q == IDLE) ? bus.dmem_addr[c_AW+1:2] : idx_q;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .en_i    (w_sram_en),
        .we_i    (state_q == WAIT),
        .be_i    (mask_q),
        .idx_i   (w_sram_idx),
        .wdata_i (wdata_q),
        .rdata_o (w_sram_rdata)
    );

    // Stall the core unless idle without a request, or in the response cycle.
    always_comb begin
        bus.dmem_valid = 1'b0;
        case (state_q)
            IDLE:    bus.dmem_valid = !bus.dmem_req;
            WAIT:    bus.dmem_valid = 1'b0;
            DONE:    bus.dmem_valid = 1'b1;
            default: bus.dmem_valid = 1'b0;
        endcase
    end

    assign bus.dmem_rdata = rdata_q;
    assign bus.dmem_err   = err_q;

    // Request FSM: latch at acceptance, count wait states, register response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.dmem_req) begin
                        we_q    <= bus.dmem_we;
                        idx_q   <= bus.dmem_addr[c_AW+1:2];
                        wdata_q <= bus.dmem_wdata;
                        mask_q  <= bus.dmem_mask;
                        bad_q   <= w_bad;
                        cnt_q   <= c_CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q <= (we_q || bad_q) ? 32'd0
                                                   : (w_sram_rdata & lane_bits(mask_q));
                        err_q   <= bad_q;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder with a behavioural
//             word-array reference model and randomized transactions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    logic [31:0] ref_mem [int];

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] addr, input logic [3:0] m);
        bit legal;
        legal = (m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
        return !legal || (addr >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        r = 32'd0;
        for (int b = 0; b < 4; b++) if (m[b]) r = r | (32'hFF << (8 * b));
        return r;
    endfunction

    // One transaction: checks stall length, DONE response, then updates model.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] m, input bit hold, input string tag);
        int          lows;
        bit          done;
        bit          e;
        logic [31:0] exp_rd;
        int          w;
        @(negedge clk);
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = we;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wd;
        bus.dmem_mask  = m;
        lows = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (bus.dmem_valid) begin
                done = 1'b1;
            end else begin
                lows++;
                @(negedge clk);
                if (!hold) begin
                    bus.dmem_req   = 1'b0;
                    bus.dmem_we    = 1'($urandom);
                    bus.dmem_addr  = $urandom;
                    bus.dmem_wdata = $urandom;
                    bus.dmem_mask  = 4'($urandom);
                end
            end
        end
        check({tag, "_timeout"}, 32'(done), 32'd1);
        check({tag, "_stall"}, 32'(lows), 32'(WAITC + 1));
        e = ref_err(addr, m);
        w = int'(addr >> 2);
        exp_rd = 32'd0;
        if (!e && !we) exp_rd = ref_mem[w] & expand(m);
        check({tag, "_err"}, 32'(bus.dmem_err), 32'(e));
        check({tag, "_rdata"}, bus.dmem_rdata, exp_rd);
        if (!e && we) ref_mem[w] = (ref_mem[w] & ~expand(m)) | (wd & expand(m));
    endtask

    initial begin
        logic [3:0]  legal_masks [7];
        logic [31:0] a;
        logic [3:0]  m;
        legal_masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        vectors = 0;
        errors  = 0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = 32'd0;
        bus.dmem_wdata = 32'd0;
        bus.dmem_mask  = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.dmem_valid), 32'd1);
        check("rst_rdata", bus.dmem_rdata, 32'd0);
        check("rst_err", 32'(bus.dmem_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_valid", 32'(bus.dmem_valid), 32'd1);
        check("idle_err", 32'(bus.dmem_err), 32'd0);

        // Give words 0..15 defined contents; word 8 (0x20) is 0x11111111.
        for (int i = 0; i < 16; i++)
            txn(1'b1, 32'(i * 4), (i == 8) ? 32'h1111_1111 : $urandom, 4'b1111, 1'b0, "init");

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, "st_word");
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "ld_word");
        txn(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0, "st_byte");
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "ld_merged");
        check("merged_model", ref_mem[4], 32'hDEAD_BEAA);
        txn(1'b0, 32'h10, 32'h0, 4'b1100, 1'b0, "ld_h1");
        txn(1'b0, 32'h10, 32'h0, 4'b0101, 1'b0, "ld_badmask");
        txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b0, "st_range");
        txn(1'b1, 32'h10, 32'h1234_5678, 4'b0000, 1'b0, "st_mask0");
        txn(1'b0, 32'h0, 32'h0, 4'b1111, 1'b0, "ld_w0");
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, "ld_w4_kept");

        // Reset in the middle of WAIT of a store to 0x20.
        @(negedge clk);
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = 1'b1;
        bus.dmem_addr  = 32'h20;
        bus.dmem_wdata = 32'h2222_2222;
        bus.dmem_mask  = 4'b1111;
        @(negedge clk);
        bus.dmem_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.dmem_valid), 32'd1);
        check("midrst_rdata", bus.dmem_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, "ld_after_rst");

        // Back-to-back loads with the request held through DONE.
        txn(1'b0, 32'h20, 32'h0, 4'b1111, 1'b1, "b2b_a");
        txn(1'b0, 32'h20, 32'h0, 4'b1111, 1'b1, "b2b_b");
        txn(1'b0, 32'h20, 32'h0, 4'b1111, 1'b1, "b2b_c");
        bus.dmem_req = 1'b0;
        @(negedge clk);
        #1;
        check("b2b_idle", 32'(bus.dmem_valid), 32'd1);

        // Randomized traffic over the defined region plus out-of-range.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
            else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 1) == 0) m = legal_masks[$urandom_range(0, 6)];
            else m = 4'($urandom_range(0, 15));
            txn(1'($urandom), a, $urandom, m, 1'b0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32I core. It is the far end of the core's load/store handshake and generates the `dmem_valid` that stalls the program counter while an access is in flight.
- Accepts one load or store request at a time and services it from an internal byte-enabled word array with a fixed, parameterised wait-state count.
- Returns lane-aligned read data plus an error flag for illegal byte masks or out-of-range addresses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, at least 2.
- WAIT_CYCLES, 2, wait-state cycles before the response; legal range 1 to 15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dmem_req  in  1  request strobe from the core.
- dmem_we  in  1  1 means store, 0 means load; sampled with dmem_req.
- dmem_addr  in  32  byte address; addr[1:0] is ignored and bytes are selected by dmem_mask.
- dmem_wdata  in  32  store data, already lane-aligned by the core.
- dmem_mask  in  4  byte-lane enables; bit i selects byte i.
- dmem_valid  out  1  0 means the core must stall; 1 means idle or response ready.
- dmem_rdata  out  32  load data; unmasked lanes read as zero.
- dmem_err  out  1  error response, qualified by the DONE state.

Behaviour:
- FSM states are IDLE, WAIT and DONE.
- Reset state: state = IDLE, wait counter = 0, dmem_rdata = 0, dmem_err = 0, dmem_valid = 1.
- The array is not reset; its contents are undefined after power-up.
- dmem_valid is combinational:
  - IDLE: dmem_valid = !dmem_req.
  - WAIT: dmem_valid = 0.
  - DONE: dmem_valid = 1.
- IDLE with dmem_req = 1 (acceptance cycle T):
  - Latch we, word index addr[log2(DEPTH_WORDS)+1:2], wdata, mask and the legality result.
  - Load counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - Counter != 0: decrement.
  - Counter == 0: perform the access on this edge, register rdata/err, go to DONE.
- Latency: dmem_valid is low for cycles T through T+WAIT_CYCLES. DONE is cycle T+WAIT_CYCLES+1, and dmem_valid is high for exactly that cycle.
- DONE: dmem_req is ignored. Go to IDLE next cycle. The earliest next request is accepted at T+WAIT_CYCLES+2.
- Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Error conditions:
  - Any other mask, including 0000.
  - dmem_addr[31:2] >= DEPTH_WORDS.
- On error, in the DONE cycle:
  - dmem_err = 1 and dmem_rdata = 0.
  - A store does not modify the array.
- Store:
  - Bytes with mask bit set are written on the WAIT-exit edge; other bytes are kept.
  - In DONE, dmem_rdata = 0.
- Load: in DONE, dmem_rdata = word & lane-expanded mask. Sign or zero extension is done by the core.
- dmem_rdata and dmem_err hold their DONE values until the next DONE. Only the DONE cycle is architecturally meaningful.
- The core holds request inputs stable while dmem_valid = 0. The block does not depend on this, because inputs are latched at T.
- Reset asserted mid-operation:
  - Immediate return to IDLE with reset values.
  - A store whose commit edge has not yet occurred is dropped.
  - A store already committed persists.
- Read-after-write to the same word in consecutive transactions returns the new data; there is no forwarding hazard because accesses are serialised.

Decomposition:
- Shared package dmem_pkg:
  - State enum dmem_state_e (IDLE, WAIT, DONE).
  - Mask constants MASK_B0..MASK_B3, MASK_H0, MASK_H1, MASK_W.
  - Function mask_legal() returning the legality of a 4-bit mask.
- Sub-module dmem_sram: synchronous byte-enabled single-port array with ports clk, en, we, be[3:0], idx, wdata, rdata. It is instantiated once; FSM, counter and error logic stay in the top.

Test Plan:
- Reset, then idle with dmem_req = 0 -> dmem_valid = 1, dmem_err = 0, dmem_rdata = 0.
- Store word 0xDEADBEEF at 0x10 with mask 1111, then load 0x10 with mask 1111 -> each request has dmem_valid low for 3 cycles (WAIT_CYCLES=2); load DONE returns 0xDEADBEEF with err = 0.
- Store byte 0x000000AA at 0x10 with mask 0001, then load with mask 1111 -> 0xDEADBEAA. Load with mask 1100 -> 0xDEAD0000.
- Load with mask 0101, then store at address 0x00001000 (word 1024 >= DEPTH) -> both DONE with err = 1 and rdata = 0; a subsequent load of word 0 is unchanged.
- Assert rst during WAIT of a store to 0x20 (prior value 0x11111111) -> FSM in IDLE, dmem_valid = 1; reload 0x20 -> 0x11111111.
- Back-to-back loads with dmem_req held high through DONE -> the second request is accepted only in the cycle after DONE; exactly one DONE pulse per transaction.
